// File: rtl/multi_divisor_ticker.sv
// N-channel divisor tick generator: a position counter walks one period while per-channel
// phase counters flag positions that are multiples of each channel's (boundary-applied) divisor.
module multi_divisor_ticker #(
  parameter int                       NUM_CH   = 2,
  parameter int                       DIV_W    = 8,
  parameter int                       PERIOD   = 100,
  parameter logic [NUM_CH*DIV_W-1:0]  DIV_INIT = {8'd5, 8'd3},
  localparam int                      CH_W     = $clog2(NUM_CH) + 1,
  localparam int                      POS_W    = $clog2(PERIOD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clear,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] cfg_pend,
  output logic [POS_W-1:0]  pos,
  output logic [NUM_CH-1:0] hit,
  output logic              all_hit,
  output logic              none_hit,
  output logic              wrap
);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(PERIOD - 1);

  logic [POS_W-1:0]  pos_q, pos_d;
  logic              err_q;
  logic              at_last, boundary, cfg_ok;
  logic [NUM_CH-1:0] ch_en, pend;

  assign at_last  = (pos_q == POS_LAST);
  // Clear and the natural wrap share one boundary path so staged divisors land coherently.
  assign boundary = clear | (en & at_last);
  assign cfg_ok   = (cfg_ch < CH_W'(NUM_CH));

  always_comb begin
    pos_d = pos_q;
    if (boundary)
      pos_d = '0;
    else if (en)
      pos_d = pos_q + POS_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q <= '0;
      err_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      err_q <= cfg_valid & ~cfg_ok;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DIV_W-1:0] act_q, act_d;
      logic [DIV_W-1:0] stg_q, stg_d;
      logic [DIV_W-1:0] phase_q, phase_d;
      logic             pend_q, pend_d;
      logic             wr;

      assign wr = cfg_valid & cfg_ok & (cfg_ch == CH_W'(gi));

      // A write in a boundary cycle stages after the old staged value has been applied.
      always_comb begin
        act_d   = act_q;
        stg_d   = stg_q;
        phase_d = phase_q;
        pend_d  = pend_q;
        if (boundary) begin
          act_d   = stg_q;
          phase_d = '0;
          pend_d  = 1'b0;
        end else if (en) begin
          phase_d = (phase_q == act_q - DIV_W'(1)) ? '0 : phase_q + DIV_W'(1);
        end
        if (wr) begin
          stg_d  = cfg_div;
          pend_d = 1'b1;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          act_q   <= DIV_INIT[gi*DIV_W +: DIV_W];
          stg_q   <= DIV_INIT[gi*DIV_W +: DIV_W];
          phase_q <= '0;
          pend_q  <= 1'b0;
        end else begin
          act_q   <= act_d;
          stg_q   <= stg_d;
          phase_q <= phase_d;
          pend_q  <= pend_d;
        end
      end

      assign ch_en[gi] = |act_q;
      assign hit[gi]   = ch_en[gi] & (phase_q == '0);
      assign pend[gi]  = pend_q;
    end
  endgenerate

  assign pos      = pos_q;
  assign cfg_err  = err_q;
  assign cfg_pend = pend;
  assign all_hit  = (|ch_en) & (&(hit | ~ch_en));
  assign none_hit = ~|hit;
  assign wrap     = at_last & en & ~clear;

endmodule

// File: tb/tb_multi_divisor_ticker.sv
// Directed and randomized checks of multi_divisor_ticker against a modulo-arithmetic model.
module tb_multi_divisor_ticker;

  logic       clk = 1'b0;
  logic       reset, en, clear, cfg_valid;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_err;
  logic [1:0] cfg_pend;
  logic [6:0] pos;
  logic [1:0] hit;
  logic       all_hit, none_hit, wrap;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: position, active/staged divisors, pending flags, error pulse.
  int pos_m;
  int act_m[2];
  int stg_m[2];
  bit pend_m[2];
  bit err_m;

  multi_divisor_ticker dut (
    .clk(clk), .reset(reset), .en(en), .clear(clear),
    .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_err(cfg_err), .cfg_pend(cfg_pend), .pos(pos), .hit(hit),
    .all_hit(all_hit), .none_hit(none_hit), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (pos_m=%0d)", tag, obs, exp, pos_m);
    end
  endtask

  function automatic bit hit_m(input int i);
    return act_m[i] != 0 && (pos_m % act_m[i]) == 0;
  endfunction

  task automatic check_all();
    bit any_en, all_ok;
    logic [1:0] hv, pv;
    any_en = 0;
    all_ok = 1;
    for (int i = 0; i < 2; i++) begin
      hv[i] = hit_m(i);
      pv[i] = pend_m[i];
      if (act_m[i] != 0) begin
        any_en = 1;
        if (!hv[i]) all_ok = 0;
      end
    end
    check("pos", 32'(pos), 32'(pos_m));
    check("hit", 32'(hit), 32'(hv));
    check("all_hit", 32'(all_hit), 32'(any_en && all_ok));
    check("none_hit", 32'(none_hit), 32'(hv == 2'b00));
    check("wrap", 32'(wrap), 32'(pos_m == 99 && en && !clear));
    check("cfg_pend", 32'(cfg_pend), 32'(pv));
    check("cfg_err", 32'(cfg_err), 32'(err_m));
  endtask

  task automatic model_reset();
    pos_m = 0;
    act_m[0] = 3; act_m[1] = 5;
    stg_m[0] = 3; stg_m[1] = 5;
    pend_m[0] = 0; pend_m[1] = 0;
    err_m = 0;
  endtask

  task automatic model_step();
    bit bnd;
    bnd = clear || (en && pos_m == 99);
    err_m = cfg_valid && cfg_ch >= 2;
    if (bnd) begin
      pos_m = 0;
      for (int i = 0; i < 2; i++) begin
        act_m[i] = stg_m[i];
        pend_m[i] = 0;
      end
    end else if (en) begin
      pos_m = pos_m + 1;
    end
    if (cfg_valid && cfg_ch < 2) begin
      stg_m[cfg_ch] = int'(cfg_div);
      pend_m[cfg_ch] = 1;
    end
  endtask

  // One clock: drive at the falling edge, check before the rising edge, then advance the model.
  task automatic step(input logic e, input logic c, input logic v,
                      input logic [1:0] ch, input logic [7:0] d);
    en = e; clear = c; cfg_valid = v; cfg_ch = ch; cfg_div = d;
    #1;
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic async_reset();
    en = 0; clear = 0; cfg_valid = 0; cfg_ch = 0; cfg_div = 0;
    #1 reset = 1;
    #1;
    model_reset();
    check_all();
    #2 reset = 0;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1; en = 0; clear = 0; cfg_valid = 0; cfg_ch = 0; cfg_div = 0;
    model_reset();
    #12;
    check_all();
    reset = 0;
    @(negedge clk);

    // Default divisors over a full period and into the next.
    for (int k = 0; k < 102; k++) step(1, 0, 0, 0, 0);

    // Staged write to ch1 applies only at the next period.
    for (int k = 0; k < 200 && pos_m != 40; k++) step(1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 7);
    for (int k = 0; k < 200 && pos_m != 0; k++) step(1, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) step(1, 0, 0, 0, 0);

    // Hold with en low.
    for (int k = 0; k < 200 && pos_m != 12; k++) step(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0);

    // Out-of-range channel writes.
    step(1, 0, 1, 2, 9);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 3, 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Disabled channels.
    step(1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    for (int k = 0; k < 30; k++) step(1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0);
    step(1, 1, 0, 0, 0);
    for (int k = 0; k < 10; k++) step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 1, 200);
    step(1, 1, 0, 0, 0);
    for (int k = 0; k < 102; k++) step(1, 0, 0, 0, 0);

    // Clear and write on the same channel in the same cycle.
    step(1, 0, 1, 0, 6);
    step(1, 0, 1, 1, 4);
    step(1, 1, 1, 0, 4);
    for (int k = 0; k < 15; k++) step(1, 0, 0, 0, 0);
    for (int k = 0; k < 200 && pos_m != 57; k++) step(1, 0, 0, 0, 0);
    async_reset();
    for (int k = 0; k < 10; k++) step(1, 0, 0, 0, 0);

    // Randomized traffic, including a wrap-cycle write and a mid-run reset.
    for (int k = 0; k < 600; k++) begin
      logic e, c, v;
      logic [1:0] ch;
      logic [7:0] d;
      e  = ($urandom_range(0, 9) != 0);
      c  = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 5) == 0);
      ch = 2'($urandom_range(0, 3));
      d  = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(100, 255)) : 8'($urandom_range(0, 12));
      if (pos_m == 99 && $urandom_range(0, 1) == 1) begin
        v = 1;
        ch = 2'($urandom_range(0, 1));
      end
      step(e, c, v, ch, d);
      if (k == 300) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
